// File: rtl/fifo_32_pkg.sv
// Shared Memory package: word width and the pointer-width helper used by the FIFO files.
package fifo_32_pkg;

  localparam int WORD_WIDTH = 32;

  // Pointer width for a DEPTH-entry store; kept at least 1 bit so DEPTH=1 still elaborates.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_32_if.sv
// Push/pop handshake and occupancy status of the 32-bit FIFO.
interface fifo_32_if
  import fifo_32_pkg::*;
#(
  parameter int DEPTH = 8
);
  localparam int CW = ptr_w(DEPTH) + 1;

  logic                  wr_en;
  logic [WORD_WIDTH-1:0] D;
  logic                  rd_en;
  logic [WORD_WIDTH-1:0] Q;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;

  modport master (output wr_en, D, rd_en, input Q, full, empty, count);
  modport slave  (input wr_en, D, rd_en, output Q, full, empty, count);
endinterface

// File: rtl/fifo_32_ptr.sv
// Wrapping storage pointer: advances on inc, rolls DEPTH-1 -> 0, cleared by async reset.
module fifo_ptr
  import fifo_32_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inc,
  output logic [ptr_w(DEPTH)-1:0] ptr
);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    ptr <= '0;
    else if (inc) ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
  end
endmodule

// File: rtl/fifo_32.sv
// 32-bit synchronous FIFO with registered output word and count-decoded full/empty flags.
module fifo_32
  import fifo_32_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic      clk,
  input  logic      reset,
  fifo_32_if.slave  bus
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_r;
  logic             full, empty, pop, push;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);

  // A pop frees the slot the same-edge push writes, so full only blocks a lone push.
  assign pop  = bus.rd_en & ~empty;
  assign push = bus.wr_en & (~full | pop);

  fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (.clk(clk), .reset(reset), .inc(push), .ptr(wr_ptr));
  fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (.clk(clk), .reset(reset), .inc(pop),  .ptr(rd_ptr));

  // Storage is never cleared; reset only keeps a write from landing while it is held.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= bus.D;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      q_r <= '0;
    end else begin
      if (pop) q_r <= mem[rd_ptr];
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.Q     = q_r;
  assign bus.count = cnt;
  assign bus.full  = full;
  assign bus.empty = empty;
endmodule

// File: tb/tb_fifo_32.sv
// Directed bench for fifo_32: pops queue their expected Q, a monitor compares after each pop edge.
module tb_fifo_32;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_q [$];

  fifo_32_if #(.DEPTH(DEPTH)) bus ();

  fifo_32 #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle from a negedge; a pop records the Q the monitor must see after the edge.
  task automatic step(input logic w, input logic [31:0] d, input logic r, input logic [31:0] eq);
    bus.wr_en = w;
    bus.D     = d;
    bus.rd_en = r;
    if (r) exp_q.push_back(eq);
    @(posedge clk);
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic flags(input string name, input int c, input logic f, input logic e);
    chk({name, ".count"}, 32'(bus.count), 32'(c));
    chk({name, ".full"},  32'(bus.full),  32'(f));
    chk({name, ".empty"}, 32'(bus.empty), 32'(e));
  endtask

  // Monitor: after every edge that carried a pop request, compare Q with the scoreboard head.
  always @(posedge clk) begin
    if (!reset && bus.rd_en) begin
      #2;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_q: got %0d with no expected entry", bus.Q);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.Q !== e) begin
          bad++;
          $display("FAIL pop_q: got %0d expected %0d", bus.Q, e);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.D = '0;
    @(negedge clk);
    chk("rst.Q", bus.Q, 0);
    flags("rst", 0, 1'b0, 1'b1);
    reset = 1'b0;

    // single word and hold
    step(1'b1, 32'd52, 1'b0, '0);
    flags("single.push", 1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 32'd52);
    flags("single.pop", 0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);
    chk("single.hold", bus.Q, 52);

    // fill, overflow, drain, underflow
    for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b0, '0);
    flags("fill", 8, 1'b1, 1'b0);
    step(1'b1, 32'd99, 1'b0, '0);
    flags("overflow", 8, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) step(1'b0, '0, 1'b1, 32'(i));
    flags("drain", 0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 32'd8);
    flags("underflow", 0, 1'b0, 1'b1);

    // wrap-around
    for (int i = 1; i <= 6; i++) step(1'b1, 32'(i), 1'b0, '0);
    for (int i = 1; i <= 6; i++) step(1'b0, '0, 1'b1, 32'(i));
    for (int i = 10; i <= 17; i++) step(1'b1, 32'(i), 1'b0, '0);
    flags("wrap.full", 8, 1'b1, 1'b0);
    for (int i = 10; i <= 17; i++) step(1'b0, '0, 1'b1, 32'(i));
    flags("wrap.drain", 0, 1'b0, 1'b1);

    // push+pop while full
    for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b0, '0);
    step(1'b1, 32'd77, 1'b1, 32'd1);
    flags("full.both", 8, 1'b1, 1'b0);
    for (int i = 2; i <= 8; i++) step(1'b0, '0, 1'b1, 32'(i));
    step(1'b0, '0, 1'b1, 32'd77);
    flags("full.drain", 0, 1'b0, 1'b1);

    // push+pop while empty: only the push lands
    step(1'b1, 32'd5, 1'b1, 32'd77);
    flags("empty.both", 1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 32'd5);
    flags("empty.drain", 0, 1'b0, 1'b1);

    // async reset mid-operation, with a push held across an edge during reset
    for (int i = 1; i <= 5; i++) step(1'b1, 32'(i), 1'b0, '0);
    flags("pre_rst", 5, 1'b0, 1'b0);
    #5 reset = 1'b1;
    #1;
    chk("arst.Q", bus.Q, 0);
    flags("arst", 0, 1'b0, 1'b1);
    bus.wr_en = 1'b1;
    bus.D = 32'd66;
    @(negedge clk);
    bus.wr_en = 1'b0;
    flags("rst_hold", 0, 1'b0, 1'b1);
    reset = 1'b0;
    step(1'b1, 32'd3, 1'b0, '0);
    flags("post_rst.push", 1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 32'd3);
    flags("post_rst.pop", 0, 1'b0, 1'b1);

    step(1'b0, '0, 1'b0, '0);
    chk("sb.leftover", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
